// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-boundary strobe: tick is high on the last cycle of each CLKS_PER_BIT window.
// clear restarts the window so a new frame starts on a full bit time.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || tick) cnt <= '0;
        else                      cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter, LSB first, 8N1 by default.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t                state, state_nx;
    logic [DATA_BITS-1:0]     shift_reg, shift_nx;
    logic [IDX_W-1:0]         bit_idx, idx_nx;
    logic                     tick, clear, accept;
    logic                     tx_d, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                     parity_q;
`endif

    assign accept = (state == IDLE) && send;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
            bit_idx   <= idx_nx;
            tx        <= tx_d;
            busy      <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)         parity_q <= 1'b0;
        else if (accept) parity_q <= ^data;
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (send) state_nx = START;
            START:  if (tick) state_nx = DATA;
            DATA:   if (tick && bit_idx == IDX_W'(DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
            PARITY: if (tick) state_nx = STOP;
`else
                        state_nx = STOP;
`endif
            STOP:   if (tick) state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    // tx/busy are computed from the next state so the registered line
    // changes on the same edge as the state does.
    always_comb begin
        shift_nx = shift_reg;
        idx_nx   = bit_idx;
        clear    = 1'b0;
        if (accept) begin
            shift_nx = data;
            idx_nx   = '0;
            clear    = 1'b1;
        end else if (state == DATA && tick) begin
            shift_nx = shift_reg >> 1;
            idx_nx   = bit_idx + IDX_W'(1);
        end

        tx_d   = 1'b1;
        busy_d = (state_nx != IDLE);
        case (state_nx)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_nx[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4; follows UART_TX_PARITY_EN.
module tb_uart_transmitter;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, busy;
    int         n_chk = 0;
    int         n_err = 0;

    uart_transmitter #(.CLKS_PER_BIT(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .data (data),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a frame with byte d and check every cycle of it. exp_par is the
    // hand-computed even parity. At cycle glitch_at a send with d_new is pulsed;
    // with hold set, send stays high throughout.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic exp_par,
                             input logic [7:0] d_new, input int glitch_at, input bit hold);
        logic exp_tx;
        send = 1'b1;
        data = d;
        step();
        for (int c = 0; c < NBITS * N; c++) begin
            int b = c / N;
            if (b == 0)              exp_tx = 1'b0;
            else if (b <= 8)         exp_tx = d[b-1];
            else if (b == NBITS - 1) exp_tx = 1'b1;
            else                     exp_tx = exp_par;
            chk({tag, "_tx"}, 32'(tx), 32'(exp_tx));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (c == glitch_at) begin
                send = 1'b1;
                data = d_new;
            end else if (!hold) begin
                send = 1'b0;
            end
            step();
        end
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
        chk({tag, "_end_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        rst = 1'b1;
        step(); step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        // basic frames
        run_frame("a5", 8'hA5, 1'b0, 8'h00, -1, 1'b0);
        step();
        run_frame("3c", 8'h3C, 1'b0, 8'h00, -1, 1'b0);
        step();
`ifdef UART_TX_PARITY_EN
        run_frame("07", 8'h07, 1'b1, 8'h00, -1, 1'b0);
        step();
        run_frame("03", 8'h03, 1'b0, 8'h00, -1, 1'b0);
        step();
`endif

        // send pulse with new data mid-frame must be ignored
        run_frame("ign", 8'h55, 1'b0, 8'hFF, 3 * N + 1, 1'b0);
        for (int i = 0; i < 2 * N; i++) begin
            chk("ign_no2nd_busy", 32'(busy), 32'd0);
            chk("ign_no2nd_tx", 32'(tx), 32'd1);
            step();
        end

        // send held high: one idle cycle then next frame
        run_frame("hold", 8'h00, 1'b0, 8'h00, -1, 1'b1);
        step();
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_tx", 32'(tx), 32'd0);
        send = 1'b0;
        repeat (NBITS * N) step();
        chk("hold_done_busy", 32'(busy), 32'd0);
        step();

        // reset during data bit 3 of 0x00
        send = 1'b1;
        data = 8'h00;
        step();
        send = 1'b0;
        repeat (4 * N + 1) step();
        chk("midrst_pre_tx", 32'(tx), 32'd0);
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2 * N) step();
        chk("midrst_idle_tx", 32'(tx), 32'd1);
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        run_frame("post_rst", 8'h5A, 1'b0, 8'h00, -1, 1'b0);
        step();

        // reset wins over send on the same edge
        rst  = 1'b1;
        send = 1'b1;
        data = 8'hC3;
        step();
        chk("rstsend_tx", 32'(tx), 32'd1);
        chk("rstsend_busy", 32'(busy), 32'd0);
        rst  = 1'b0;
        send = 1'b0;
        step();
        chk("rstsend_after_tx", 32'(tx), 32'd1);
        chk("rstsend_after_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
